// File: rtl/bnn_neuron_seq.sv
// bnn_neuron_seq
// Sequencer for a binarized-neuron accumulate ALU. For each of N_NEU neurons
// it reads N_IN x/w bit pairs, steers an external add1/sub1 ALU with
// x XOR w, keeps the running sum in a signed accumulator, and writes one
// sign-activated output bit per neuron.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          pass request (IDLE only), synchronous abort
//   busy, done            pass in progress, one-cycle completion pulse
//   x_addr / x_rd_data    x bit memory, 1-cycle read latency
//   w_addr / w_rd_data    w bit memory, 1-cycle read latency
//   alu_op, alu_a_lsb,    ALU controls: 0 = add1, 1 = sub1; increment bit;
//   alu_b, alu_out        operand (accumulator) and result
//   y_we, y_addr, y_data  output bit buffer write port
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | issuing one x/w address pair per cycle for neuron n
// DRAIN | accumulating the last pair whose data is now on the bus
// WRITE | y_we high with the sign of the finished sum; next neuron or DONE
// DONE  | one-cycle done pulse, then IDLE
module bnn_neuron_seq #(
    parameter int N_IN  = 4,
    parameter int N_NEU = 2,
    parameter int ACC_W = 12,
    parameter int XA_W  = 2,
    parameter int WA_W  = 3,
    parameter int YA_W  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [XA_W-1:0]  x_addr,
    input  logic             x_rd_data,
    output logic [WA_W-1:0]  w_addr,
    input  logic             w_rd_data,
    output logic             alu_op,
    output logic             alu_a_lsb,
    output logic [ACC_W-1:0] alu_b,
    input  logic [ACC_W-1:0] alu_out,
    output logic             y_we,
    output logic [YA_W-1:0]  y_addr,
    output logic             y_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [XA_W-1:0] I_LAST = XA_W'(N_IN - 1);
    localparam logic [YA_W-1:0] N_LAST = YA_W'(N_NEU - 1);

    state_t           state;
    logic [XA_W-1:0]  i_cnt;
    logic [WA_W-1:0]  w_ptr;
    logic [YA_W-1:0]  n_cnt;
    logic             vld;
    logic [ACC_W-1:0] acc;

    // w_ptr runs continuously across neurons, so it always equals n*N_IN + i
    // without a multiplier.
    assign x_addr    = i_cnt;
    assign w_addr    = w_ptr;
    assign alu_b     = acc;
    assign alu_a_lsb = vld;
    // Gated with vld so the op is quiet while no valid data is on the bus.
    assign alu_op    = vld & (x_rd_data ^ w_rd_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            i_cnt  <= '0;
            w_ptr  <= '0;
            n_cnt  <= '0;
            vld    <= 1'b0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            y_we   <= 1'b0;
            y_addr <= '0;
            y_data <= 1'b0;
        end else if (abort) begin
            state <= S_IDLE;
            i_cnt <= '0;
            w_ptr <= '0;
            n_cnt <= '0;
            vld   <= 1'b0;
            acc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            y_we  <= 1'b0;
        end else begin
            done <= 1'b0;
            y_we <= 1'b0;
            if (vld) begin
                acc <= alu_out;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        i_cnt <= '0;
                        w_ptr <= '0;
                        n_cnt <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    vld <= 1'b1;
                    if (i_cnt == I_LAST) begin
                        // i holds at the last index rather than wrapping;
                        // WRITE brings it back to 0.
                        if (n_cnt != N_LAST) begin
                            w_ptr <= w_ptr + WA_W'(1);
                        end
                        state <= S_DRAIN;
                    end else begin
                        i_cnt <= i_cnt + XA_W'(1);
                        w_ptr <= w_ptr + WA_W'(1);
                    end
                end
                S_DRAIN: begin
                    vld    <= 1'b0;
                    y_we   <= 1'b1;
                    y_addr <= n_cnt;
                    // alu_out is the final sum being loaded into acc this edge.
                    y_data <= ~alu_out[ACC_W-1];
                    state  <= S_WRITE;
                end
                S_WRITE: begin
                    acc   <= '0;
                    i_cnt <= '0;
                    if (n_cnt == N_LAST) begin
                        n_cnt <= '0;
                        w_ptr <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        n_cnt <= n_cnt + YA_W'(1);
                        state <= S_RUN;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
